// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared tag widths, FU-type codes and reservation-station entry states
package alu_rs_pkg;
    localparam int TAG_W = 8;
    localparam logic [TAG_W-1:0] NO_TAG = 8'd0;
    localparam logic [2:0] FU_ALU = 3'd1;
    localparam logic [2:0] FU_LSU = 3'd2;
    localparam logic [2:0] FU_MUL = 3'd3;
    localparam logic [2:0] FU_DIV = 3'd4;
    typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} rs_state_e;
endpackage

// File: rtl/rs_entry.sv
// rs_entry: one station slot (clk, rst active-low async; issue alloc/op/q/v in, cdb in, disp in; is_free/is_ready/op/vj/vk out)
module rs_entry
    import alu_rs_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag,
    input  logic             alloc,
    input  logic [3:0]       issue_op,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_rs_num,
    input  logic [31:0]      cdb_data,
    input  logic             disp,
    output logic             is_free,
    output logic             is_ready,
    output logic [3:0]       op,
    output logic [31:0]      vj,
    output logic [31:0]      vk
);
    rs_state_e st;
    logic [TAG_W-1:0] qj, qk;
    logic cdb_hit, fj, fk, wj, wk;
    assign cdb_hit = cdb_valid && cdb_rs_num != NO_TAG;
    assign fj = cdb_hit && issue_qj == cdb_rs_num;
    assign fk = cdb_hit && issue_qk == cdb_rs_num;
    assign wj = cdb_hit && qj == cdb_rs_num;
    assign wk = cdb_hit && qk == cdb_rs_num;
    assign is_free = st == FREE;
    assign is_ready = st == READY;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st <= FREE;
            op <= '0;
            qj <= NO_TAG;
            qk <= NO_TAG;
            vj <= '0;
            vk <= '0;
        end else case (st)
            FREE: if (alloc) begin
                op <= issue_op;
                qj <= fj ? NO_TAG : issue_qj;
                qk <= fk ? NO_TAG : issue_qk;
                vj <= fj ? cdb_data : issue_vj;
                vk <= fk ? cdb_data : issue_vk;
                st <= (fj || issue_qj == NO_TAG) && (fk || issue_qk == NO_TAG) ? READY : WAIT;
            end
            WAIT: begin
                if (wj) begin
                    qj <= NO_TAG;
                    vj <= cdb_data;
                end
                if (wk) begin
                    qk <= NO_TAG;
                    vk <= cdb_data;
                end
                if (qj == NO_TAG && qk == NO_TAG) st <= READY;
            end
            READY: if (disp) st <= EXEC;
            EXEC: if (cdb_hit && cdb_rs_num == tag) st <= FREE;
            default: st <= FREE;
        endcase
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station (issue in/tag out, CDB in, dispatch out; rst active-low async)
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [2:0] FU_TYPE = FU_ALU
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_rs_num,
    input  logic [31:0]      cdb_data,
    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [3:0]       disp_op,
    output logic [31:0]      disp_vj,
    output logic [31:0]      disp_vk,
    output logic [TAG_W-1:0] disp_tag
);
    logic [DEPTH-1:0] free, rdy, alloc, disp;
    logic [3:0]  op [DEPTH];
    logic [31:0] vj [DEPTH];
    logic [31:0] vk [DEPTH];
    logic [4:0] free_idx, rdy_idx, sel, hold_idx;
    logic hold_v;
    assign issue_ready = |free;
    assign disp_valid = |rdy;
    assign issue_tag = {FU_TYPE, free_idx + 5'd1};
    // a stalled entry stays presented even if a lower-index entry becomes READY
    assign sel = hold_v ? hold_idx : rdy_idx;
    always_comb begin
        free_idx = '0;
        rdy_idx = '0;
        disp_op = '0;
        disp_vj = '0;
        disp_vk = '0;
        disp_tag = NO_TAG;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free[i]) free_idx = 5'(i);
            if (rdy[i]) rdy_idx = 5'(i);
        end
        for (int i = 0; i < DEPTH; i++) if (disp_valid && sel == 5'(i)) begin
            disp_op = op[i];
            disp_vj = vj[i];
            disp_vk = vk[i];
            disp_tag = {FU_TYPE, 5'(i + 1)};
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            hold_v <= 1'b0;
            hold_idx <= '0;
        end else begin
            hold_v <= disp_valid && !disp_ready;
            hold_idx <= sel;
        end
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign alloc[g] = issue_valid && issue_ready && free_idx == 5'(g);
        assign disp[g] = disp_valid && disp_ready && sel == 5'(g);
        rs_entry u_ent (
            .clk(clk), .rst(rst), .tag({FU_TYPE, 5'(g + 1)}), .alloc(alloc[g]),
            .issue_op(issue_op), .issue_qj(issue_qj), .issue_qk(issue_qk),
            .issue_vj(issue_vj), .issue_vk(issue_vk),
            .cdb_valid(cdb_valid), .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
            .disp(disp[g]), .is_free(free[g]), .is_ready(rdy[g]),
            .op(op[g]), .vj(vj[g]), .vk(vk[g])
        );
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs
module tb_alu_rs;
    logic clk = 0, rst = 0;
    logic issue_valid = 0, issue_ready, cdb_valid = 0, disp_valid, disp_ready = 0;
    logic [3:0] issue_op = 0, disp_op;
    logic [7:0] issue_qj = 0, issue_qk = 0, issue_tag, cdb_rs_num = 0, disp_tag;
    logic [31:0] issue_vj = 0, issue_vk = 0, cdb_data = 0, disp_vj, disp_vk;
    int n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    alu_rs dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic iss(input logic [3:0] op, input logic [7:0] qj, input logic [31:0] vj,
                       input logic [7:0] qk, input logic [31:0] vk);
        issue_valid = 1; issue_op = op; issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
        #1;
    endtask
    task automatic cdb(input logic [7:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_rs_num = t; cdb_data = d;
    endtask
    task automatic quiet();
        issue_valid = 0; cdb_valid = 0; cdb_rs_num = 0; disp_ready = 0;
    endtask
    initial begin
        tick(); tick();
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_issue_tag", issue_tag, 8'h21);
        chk("rst_disp_tag", disp_tag, 0);
        rst = 1;
        tick();
        iss(1, 0, 5, 0, 7);
        chk("t1_issue_tag", issue_tag, 8'h21);
        tick(); quiet();
        chk("t1_disp_valid", disp_valid, 1);
        chk("t1_disp_op", disp_op, 1);
        chk("t1_disp_vj", disp_vj, 5);
        chk("t1_disp_vk", disp_vk, 7);
        chk("t1_disp_tag", disp_tag, 8'h21);
        disp_ready = 1;
        tick(); quiet();
        chk("t1_exec_disp_valid", disp_valid, 0);
        chk("t1_exec_reserved", issue_tag, 8'h22);
        cdb(8'h21, 0);
        tick(); quiet();
        chk("t1_freed_tag", issue_tag, 8'h21);
        iss(2, 8'h42, 0, 0, 3);
        tick(); quiet();
        chk("t2_wait", disp_valid, 0);
        tick();
        cdb(8'h42, 9);
        tick(); quiet();
        chk("t2_no_same_cycle_disp", disp_valid, 0);
        tick();
        chk("t2_disp_valid", disp_valid, 1);
        chk("t2_disp_vj", disp_vj, 9);
        chk("t2_disp_vk", disp_vk, 3);
        disp_ready = 1;
        tick(); quiet();
        cdb(8'h21, 0);
        tick(); quiet();
        iss(3, 8'h42, 0, 0, 0);
        cdb(8'h42, 11);
        tick(); quiet();
        chk("t3_disp_valid", disp_valid, 1);
        chk("t3_disp_vj", disp_vj, 11);
        disp_ready = 1;
        tick(); quiet();
        cdb(8'h21, 0);
        tick(); quiet();
        for (int i = 1; i <= 4; i++) begin
            iss(4'(i), 0, 32'(i * 10), 0, 32'(i));
            chk($sformatf("t4_tag%0d", i), issue_tag, 8'h20 + 8'(i));
            tick();
        end
        quiet();
        chk("t4_full", issue_ready, 0);
        iss(5, 0, 99, 0, 99);
        tick(); quiet();
        chk("t4_full_after_5th", issue_ready, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_hold_tag%0d", i), disp_tag, 8'h21);
            chk($sformatf("t4_hold_vj%0d", i), disp_vj, 10);
            tick();
        end
        disp_ready = 1;
        tick(); quiet();
        chk("t4_next_tag", disp_tag, 8'h22);
        chk("t4_next_vj", disp_vj, 20);
        chk("t4_exec_full", issue_ready, 0);
        cdb(8'h21, 0);
        tick(); quiet();
        chk("t4_freed_ready", issue_ready, 1);
        chk("t4_freed_tag", issue_tag, 8'h21);
        iss(6, 0, 100, 0, 0);
        tick(); quiet();
        chk("t4_refull", issue_ready, 0);
        rst = 0;
        tick();
        rst = 1;
        tick();
        iss(1, 0, 1, 0, 1);
        tick(); quiet();
        iss(1, 8'h55, 0, 0, 2);
        disp_ready = 1;
        tick(); quiet();
        iss(1, 0, 3, 0, 3);
        tick(); quiet();
        chk("t5_pre_disp_tag", disp_tag, 8'h23);
        chk("t5_pre_issue_tag", issue_tag, 8'h24);
        #2 rst = 0;
        #1;
        chk("t5_async_disp_valid", disp_valid, 0);
        chk("t5_async_issue_ready", issue_ready, 1);
        chk("t5_async_issue_tag", issue_tag, 8'h21);
        chk("t5_async_disp_tag", disp_tag, 0);
        tick();
        rst = 1;
        cdb(8'h55, 77);
        tick();
        cdb(8'h21, 0);
        tick(); quiet();
        tick();
        chk("t5_post_disp_valid", disp_valid, 0);
        chk("t5_post_issue_tag", issue_tag, 8'h21);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
